// File: rtl/iob_eth_rx_frame_reader_if.sv
// Output stream of the Ethernet RX frame reader: data words with a last flag
// under a valid/ready handshake.
interface iob_eth_rx_frame_reader_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] m_data_o;
   logic              m_valid_o;
   logic              m_last_o;
   logic              m_ready_i;

   modport master (
      output m_data_o,
      output m_valid_o,
      output m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o,
      input  m_valid_o,
      input  m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/iob_eth_rx_frame_reader.sv
// Ethernet RX frame reader: reads len words from the RX buffer starting at a
// base address and streams them out. The 2-cycle buffer read latency is hidden
// by a 4-entry prefetch FIFO whose credit counts reads still in flight.
module iob_eth_rx_frame_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [ADDR_W-1:0]    base_addr_i,
   input  logic [ADDR_W:0]      len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   input  logic [DATA_W-1:0]    mem_data_i,
   iob_eth_rx_frame_reader_if.master m_if
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ONE_L = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_W:0]     issued_q, issued_d;
   logic [ADDR_W:0]     len_q, len_d;
   // issue-valid pipe and the last-word tag travelling with it
   logic                v1_q, v1_d, v2_q, v2_d;
   logic                l1_q, l1_d, l2_q, l2_d;
   // prefetch FIFO
   logic [DATA_W-1:0]   fifo_data_q [4];
   logic [DATA_W-1:0]   fifo_data_d [4];
   logic                fifo_last_q [4];
   logic                fifo_last_d [4];
   logic [1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]          cnt_q, cnt_d;

   logic                issue_s, issue_last_s, credit_ok_s;
   logic                push_s, pop_s, fifo_valid_s, head_last_s;
   logic [1:0]          inflight_s;
   logic [ADDR_W:0]     issued_nxt_s;

   assign fifo_valid_s = (cnt_q != 3'd0);
   assign head_last_s  = fifo_last_q[rd_ptr_q];
   assign push_s       = v2_q;
   assign pop_s        = fifo_valid_s & m_if.m_ready_i;
   assign inflight_s   = {1'b0, v1_q} + {1'b0, v2_q};
   // occupancy includes this cycle's push; a same-cycle pop frees credit only next cycle
   assign credit_ok_s  = ({1'b0, cnt_q} + {2'b00, inflight_s}) < 4'd4;
   assign issued_nxt_s = issued_q + ONE_L;

   // Control FSM: command latch, read issue and frame completion.
   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      issued_d     = issued_q;
      len_d        = len_q;
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d     = len_i;
               rd_addr_d = base_addr_i;
               issued_d  = '0;
               if (len_i == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if ((issued_q < len_q) && credit_ok_s) begin
               issue_s   = 1'b1;
               rd_addr_d = rd_addr_q + ONE_A;
               issued_d  = issued_nxt_s;
               if (issued_nxt_s == len_q) begin
                  issue_last_s = 1'b1;
                  state_d      = ST_DRAIN;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (pop_s && head_last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read-tracking pipe: stage 2 marks the cycle the issued word is on mem_data_i.
   always_comb begin
      v1_d = issue_s;
      l1_d = issue_last_s;
      v2_d = v1_q;
      l2_d = l1_q;
   end

   // Prefetch FIFO next state: push from pipe stage 2, pop on handshake.
   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push_s) begin
         fifo_data_d[wr_ptr_q] = mem_data_i;
         fifo_last_d[wr_ptr_q] = l2_q;
         wr_ptr_d              = wr_ptr_q + 2'd1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + {2'b00, push_s} - {2'b00, pop_s};
   end

   // State, counters, pipe and FIFO registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rd_addr_q <= '0;
         issued_q  <= '0;
         len_q     <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         l1_q      <= 1'b0;
         l2_q      <= 1'b0;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         cnt_q     <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         issued_q    <= issued_d;
         len_q       <= len_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         l1_q        <= l1_d;
         l2_q        <= l2_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
      end
   end

   // Outputs are decoded directly from registers; the stream shows the FIFO head.
   assign busy_o         = (state_q != ST_IDLE);
   assign done_o         = (state_q == ST_DONE);
   assign mem_addr_o     = rd_addr_q;
   assign m_if.m_valid_o = fifo_valid_s;
   assign m_if.m_data_o  = fifo_valid_s ? fifo_data_q[rd_ptr_q] : '0;
   assign m_if.m_last_o  = fifo_valid_s ? head_last_s : 1'b0;

endmodule

// File: tb/tb_iob_eth_rx_frame_reader.sv
// Self-checking bench for iob_eth_rx_frame_reader: a buffer model with 2-cycle
// read latency, a frame-level expected-word queue and a decoupled stream monitor.
module tb_iob_eth_rx_frame_reader;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } word_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W-1:0] base_addr_i = '0;
   logic [ADDR_W:0]   len_i = '0;
   logic              busy_o, done_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_i;

   iob_eth_rx_frame_reader_if #(.DATA_W(DATA_W)) m_if ();

   iob_eth_rx_frame_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_i  (mem_data_i),
      .m_if        (m_if)
   );

   always #5 clk = ~clk;

   // buffer model: address in cycle t -> data during cycle t+2
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] d1, d2;
   always @(posedge clk) begin
      d1 <= mem[mem_addr_o];
      d2 <= d1;
   end
   assign mem_data_i = d2;

   int    n_checks = 0;
   int    n_fail   = 0;
   word_t exp_q[$];
   int    ready_mode = 0;
   int    tog_k = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
   initial begin
      m_if.m_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: m_if.m_ready_i = 1'b1;
            1: begin
               m_if.m_ready_i = ((tog_k % 4) == 0) || ((tog_k % 4) == 3);
               tog_k++;
            end
            2: m_if.m_ready_i = ($urandom_range(0, 99) < 60);
            default: m_if.m_ready_i = 1'b1;
         endcase
      end
   end

   // monitor: compare every accepted word and check stability under stall
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid_held", {63'd0, m_if.m_valid_o}, 64'd1);
               check("stall_data_held", {32'd0, m_if.m_data_o}, {32'd0, prev_data});
               check("stall_last_held", {63'd0, m_if.m_last_o}, {63'd0, prev_last});
            end
            if (m_if.m_valid_o && m_if.m_ready_i) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", {32'd0, m_if.m_data_o}, 64'hDEAD_0000_0000_0000);
               end else begin
                  e = exp_q.pop_front();
                  check("word_data", {32'd0, m_if.m_data_o}, {32'd0, e.data});
                  check("word_last", {63'd0, m_if.m_last_o}, {63'd0, e.last});
               end
            end
            prev_stall = m_if.m_valid_o && !m_if.m_ready_i;
            prev_data  = m_if.m_data_o;
            prev_last  = m_if.m_last_o;
         end
      end
   end

   // reference: a frame is the words mem[(base+i) mod DEPTH], last on i==len-1
   task automatic push_expected(input int base, input int len);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.data = mem[(base + i) % DEPTH];
         w.last = (i == len - 1);
         exp_q.push_back(w);
      end
   endtask

   // drive a start command on the next edge; returns in cycle 1
   task automatic start_cmd(input int base, input int len);
      start_i     = 1'b1;
      base_addr_i = base[ADDR_W-1:0];
      len_i       = len[ADDR_W:0];
      push_expected(base, len);
      tick();
      start_i = 1'b0;
   endtask

   // wait (bounded) for done, then check the frame was fully delivered
   task automatic finish_frame(input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (done_o) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("done_seen", {63'd0, seen}, 64'd1);
      tick();
      check("busy_after_done", {63'd0, busy_o}, 64'd0);
      check("done_one_cycle", {63'd0, done_o}, 64'd0);
      check("frame_words_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      #12;
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_done", {63'd0, done_o}, 64'd0);
      check("rst_valid", {63'd0, m_if.m_valid_o}, 64'd0);
      check("rst_last", {63'd0, m_if.m_last_o}, 64'd0);
      check("rst_data", {32'd0, m_if.m_data_o}, 64'd0);
      check("rst_addr", {53'd0, mem_addr_o}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // single-word frame latency
      start_cmd(32'h010, 1);
      check("t1_addr_c1", {53'd0, mem_addr_o}, 64'h010);
      check("t1_busy_c1", {63'd0, busy_o}, 64'd1);
      tick(); tick();
      check("t1_novalid_c3", {63'd0, m_if.m_valid_o}, 64'd0);
      tick();
      check("t1_valid_c4", {63'd0, m_if.m_valid_o}, 64'd1);
      check("t1_last_c4", {63'd0, m_if.m_last_o}, 64'd1);
      tick();
      check("t1_done_c5", {63'd0, done_o}, 64'd1);
      tick();
      check("t1_busy_c6", {63'd0, busy_o}, 64'd0);
      exp_q.delete();
      tick();

      // address wrap, back-to-back delivery
      start_cmd(32'h7FE, 4);
      check("t2_addr_c1", {53'd0, mem_addr_o}, 64'h7FE);
      tick();
      check("t2_addr_c2", {53'd0, mem_addr_o}, 64'h7FF);
      tick();
      check("t2_addr_c3", {53'd0, mem_addr_o}, 64'h000);
      tick();
      check("t2_addr_c4", {53'd0, mem_addr_o}, 64'h001);
      for (int c = 4; c <= 7; c++) begin
         check("t2_valid", {63'd0, m_if.m_valid_o}, 64'd1);
         check("t2_last", {63'd0, m_if.m_last_o}, (c == 7) ? 64'd1 : 64'd0);
         tick();
      end
      finish_frame(10);

      // backpressure with pattern 1,0,0,1
      ready_mode = 1;
      tog_k = 0;
      start_cmd($urandom_range(0, DEPTH - 1), 16);
      finish_frame(200);
      ready_mode = 0;
      tick();

      // zero-length frame
      start_cmd(32'h123, 0);
      check("t4_done_c1", {63'd0, done_o}, 64'd1);
      check("t4_busy_c1", {63'd0, busy_o}, 64'd1);
      check("t4_valid_c1", {63'd0, m_if.m_valid_o}, 64'd0);
      tick();
      check("t4_busy_c2", {63'd0, busy_o}, 64'd0);
      check("t4_done_c2", {63'd0, done_o}, 64'd0);
      check("t4_valid_c2", {63'd0, m_if.m_valid_o}, 64'd0);
      tick();

      // start while busy is ignored
      start_cmd(32'h200, 8);
      tick(); tick();
      start_i = 1'b1; base_addr_i = 11'h555; len_i = 12'd5;
      tick();
      start_i = 1'b0;
      finish_frame(60);

      // reset with two reads in flight
      start_cmd(32'h300, 16);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("t6_busy", {63'd0, busy_o}, 64'd0);
      check("t6_valid", {63'd0, m_if.m_valid_o}, 64'd0);
      check("t6_addr", {53'd0, mem_addr_o}, 64'd0);
      check("t6_data", {32'd0, m_if.m_data_o}, 64'd0);
      check("t6_last", {63'd0, m_if.m_last_o}, 64'd0);
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t6_quiet_valid", {63'd0, m_if.m_valid_o}, 64'd0);
         check("t6_quiet_done", {63'd0, done_o}, 64'd0);
      end
      start_cmd(32'h040, 2);
      finish_frame(30);

      // randomized frames with random backpressure
      ready_mode = 2;
      for (int f = 0; f < 12; f++) begin
         int len;
         len = (f == 5) ? 0 : $urandom_range(1, 40);
         start_cmd($urandom_range(0, DEPTH - 1), len);
         finish_frame(len * 10 + 40);
         tick();
      end

      // whole buffer once
      ready_mode = 0;
      start_cmd($urandom_range(0, DEPTH - 1), DEPTH);
      finish_frame(DEPTH + 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/iob_eth_rx_frame_reader.md
Name: iob_eth_rx_frame_reader

Overview:
Downstream consumer of the Ethernet RX simple-dual-port buffer read port. On a start command it reads a frame of len_i words from the buffer, beginning at base_addr_i. It hides the buffer's 2-cycle read latency with a credit-limited prefetch FIFO and delivers the words on a valid/ready stream that has a last flag. It runs in the read-port clock domain.

Parameters:
DATA_W, 32, buffer word width and stream data width
ADDR_W, 11, buffer address width; buffer depth is 2**ADDR_W words

Ports:
clk  in  1  clock; identical to the buffer read clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  command strobe; sampled only in IDLE
base_addr_i  in  ADDR_W  first word address; latched on an accepted start
len_i  in  ADDR_W+1  frame length in words, 0..2**ADDR_W; latched on an accepted start
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse when the frame is complete
mem_addr_o  out  ADDR_W  buffer read address
mem_data_i  in  DATA_W  buffer read data
m_data_o  out  DATA_W  stream data
m_valid_o  out  1  stream valid
m_last_o  out  1  high together with the final word of the frame
m_ready_i  in  1  stream ready

Behaviour:
- Reset values: busy_o=0, done_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, mem_addr_o=0, FIFO empty, all counters 0, state IDLE.
- Buffer timing contract: an address driven on mem_addr_o during cycle t returns its word on mem_data_i during cycle t+2. The block captures that word at the end of cycle t+2.
- Read tracking: a 2-stage issue-valid shift pipe records which cycles issued a read. Inflight is the number of set bits in the pipe (0..2). The last-word tag travels down the pipe with each issue.
- FIFO: 4 entries of {data, last}. Writes come from pipe stage 2. Pops happen on m_valid_o && m_ready_i. Push and pop in the same cycle are allowed, including when the FIFO is full or empty. m_data_o, m_valid_o and m_last_o reflect the FIFO head.
- Issue rule, evaluated in READ: issue when issued_cnt < len_r and fifo_count + inflight < 4. A push in the cycle counts against occupancy; a pop in the same cycle does not free credit until the next cycle.
- On each issue: mem_addr_o presents rd_addr; rd_addr increments modulo 2**ADDR_W, so addresses wrap from 2**ADDR_W-1 to 0; issued_cnt increments.
- States:
  - IDLE: busy_o=0. start_i=1 latches base and len and sets rd_addr=base_addr_i. Go to DONE if len_i==0, otherwise READ.
  - READ: busy_o=1 and reads issue per the rule above. When issued_cnt reaches len_r, go to DRAIN.
  - DRAIN: busy_o=1 and no issue. Wait until the handshake on the word with m_last_o=1, then go to DONE.
  - DONE: done_o=1 and busy_o=1 for exactly one cycle, then go to IDLE.
- Latency: with start_i sampled at edge 0 and m_ready_i=1, the first read issues in cycle 1. m_valid_o first rises in cycle 4.
- Throughput: sustained 1 word/cycle while m_ready_i=1. Once any word has been issued, m_valid_o never drops before the last word while m_ready_i stays 1.
- Backpressure: m_data_o and m_last_o stay stable while m_valid_o=1 and m_ready_i=0. No word is ever dropped or duplicated, because the FIFO can never overflow by construction.
- start_i outside IDLE is ignored, with no effect on the latched values.
- A reset mid-frame discards in-flight data, the FIFO contents and the counters immediately (async). No done_o follows.
- len_i = 2**ADDR_W reads the whole buffer once, starting at base_addr_i.

Test Plan:
- Reset, then start with base=0x010, len=1, ready=1 -> mem_addr_o=0x010 in cycle 1; m_valid_o=1 and m_last_o=1 with data=mem[0x010] in cycle 4; done_o pulses in cycle 5; busy_o=0 in cycle 6.
- base=0x7FE, len=4, ready=1 -> addresses 0x7FE, 0x7FF, 0x000, 0x001 issued in consecutive cycles; 4 words delivered on consecutive cycles; m_last_o only on the 4th word.
- len=16 with m_ready_i toggling 1,0,0,1,... -> all 16 words delivered in order and held stable while stalled; FIFO count + inflight never exceeds 4.
- len=0 -> no issue and m_valid_o stays 0; done_o pulses in cycle 1 after start; busy_o high for that cycle only.
- start_i pulsed in the middle of a len=8 frame with different base/len -> it is ignored; exactly 8 words come from the original base.
- rst_n asserted during READ with 2 reads in flight -> outputs go to reset values at once; after release, a new len=2 frame delivers exactly 2 correct words with no stale data.
